// File: rtl/eco32_bus_pkg.sv
// Shared definitions for the eco32 bus: arbiter state encoding, transfer size
// codes and the data value returned when the watchdog terminates a transfer.
package eco32_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_t;

    localparam logic [1:0]  SIZE_BYTE    = 2'b00;
    localparam logic [1:0]  SIZE_HALF    = 2'b01;
    localparam logic [1:0]  SIZE_WORD    = 2'b10;

    localparam logic [31:0] TIMEOUT_DATA = 32'h0000_0000;

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between the CPU (master 0) and the disk DMA engine
// (master 1), with a watchdog that force-completes stalled transfers.
module bus_arbiter
    import eco32_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_en,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_data_out,
    output logic [31:0] m0_data_in,
    output logic        m0_wt,
    input  logic        m1_en,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_data_out,
    output logic [31:0] m1_data_in,
    output logic        m1_wt,
    output logic        bus_en,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data_out,
    input  logic [31:0] bus_data_in,
    input  logic        bus_wt,
    output logic        bus_timeout,
    output logic [1:0]  grant
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state, state_next;
    logic             last, last_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic             sel_en;
    logic             sel_wr;
    logic [1:0]       sel_size;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_data;
    logic             hit;
    logic             done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
            grant <= 2'b00;
        end else begin
            state <= state_next;
            last  <= last_next;
            cnt   <= cnt_next;
            grant <= {state_next == GRANT1, state_next == GRANT0};
        end
    end

    always_comb begin
        sel_en   = m0_en;
        sel_wr   = m0_wr;
        sel_size = m0_size;
        sel_addr = m0_addr;
        sel_data = m0_data_out;
        if (state == GRANT1) begin
            sel_en   = m1_en;
            sel_wr   = m1_wr;
            sel_size = m1_size;
            sel_addr = m1_addr;
            sel_data = m1_data_out;
        end
    end

    // A watchdog hit masquerades as a zero-wait completion with zeroed read data.
    always_comb begin
        bus_en       = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = 2'b00;
        bus_addr     = 32'h0;
        bus_data_out = 32'h0;
        m0_wt        = 1'b1;
        m1_wt        = 1'b1;
        m0_data_in   = 32'h0;
        m1_data_in   = 32'h0;
        bus_timeout  = 1'b0;
        hit          = 1'b0;
        done         = 1'b0;
        if (state != IDLE) begin
            bus_en       = sel_en;
            bus_wr       = sel_wr;
            bus_size     = sel_size;
            bus_addr     = sel_addr;
            bus_data_out = sel_data;
            hit          = sel_en && bus_wt && (cnt == CNT_LAST);
            done         = sel_en && (!bus_wt || hit);
            bus_timeout  = hit;
            if (state == GRANT0) begin
                m0_wt      = bus_wt && !hit;
                m0_data_in = hit ? TIMEOUT_DATA : bus_data_in;
            end else begin
                m1_wt      = bus_wt && !hit;
                m1_data_in = hit ? TIMEOUT_DATA : bus_data_in;
            end
        end
    end

    // Completion hands straight over to a waiting peer, so alternation has no bubble.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (m0_en && m1_en) begin
                    state_next = last ? GRANT0 : GRANT1;
                end else if (m0_en) begin
                    state_next = GRANT0;
                end else if (m1_en) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_en) begin
                    state_next = IDLE;
                end else if (done) begin
                    last_next  = 1'b0;
                    state_next = m1_en ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (!m1_en) begin
                    state_next = IDLE;
                end else if (done) begin
                    last_next  = 1'b1;
                    state_next = m0_en ? GRANT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        cnt_next = cnt;
        if (state_next != state) begin
            cnt_next = '0;
        end else if (state != IDLE && bus_wt) begin
            cnt_next = cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// master/slave traffic compared against a transaction-level ownership model.
module tb_bus_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_en = 1'b0, m1_en = 1'b0;
    logic        m0_wr = 1'b0, m1_wr = 1'b0;
    logic [1:0]  m0_size = 2'b00, m1_size = 2'b00;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic [31:0] m0_data_out = 32'h0, m1_data_out = 32'h0;
    logic [31:0] m0_data_in, m1_data_in;
    logic        m0_wt, m1_wt;
    logic        bus_en, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_data_out;
    logic [31:0] bus_data_in = 32'h0;
    logic        bus_wt = 1'b0;
    logic        bus_timeout;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .m0_en(m0_en), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_data_out(m0_data_out), .m0_data_in(m0_data_in), .m0_wt(m0_wt),
        .m1_en(m1_en), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_data_out(m1_data_out), .m1_data_in(m1_data_in), .m1_wt(m1_wt),
        .bus_en(bus_en), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .bus_wt(bus_wt),
        .bus_timeout(bus_timeout), .grant(grant)
    );

    int checks = 0;
    int failures = 0;

    // Master-side view of what the bench is driving.
    logic        mEn[2];
    logic        mWr[2];
    logic [1:0]  mSize[2];
    logic [31:0] mAddr[2];
    logic [31:0] mData[2];
    logic        active[2];
    logic        doneFlag[2];
    int          stuckLeft = 0;

    // Reference model: who owns the bus, who was served last, how long the slave has stalled.
    int owner;
    int lastServed;
    int waitRun;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        owner      = -1;
        lastServed = 1;
        waitRun    = 0;
    endtask

    task automatic drivePorts();
        m0_en = mEn[0]; m0_wr = mWr[0]; m0_size = mSize[0]; m0_addr = mAddr[0]; m0_data_out = mData[0];
        m1_en = mEn[1]; m1_wr = mWr[1]; m1_size = mSize[1]; m1_addr = mAddr[1]; m1_data_out = mData[1];
    endtask

    task automatic clearMasters();
        for (int i = 0; i < 2; i++) begin
            mEn[i] = 1'b0; mWr[i] = 1'b0; mSize[i] = 2'b00; mAddr[i] = 32'h0; mData[i] = 32'h0;
            active[i] = 1'b0; doneFlag[i] = 1'b0;
        end
        drivePorts();
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Compare every output with the model at the falling edge, then advance the model.
    task automatic sampleCycle();
        logic        eBusEn, eBusWr, eTo, selEn, hit;
        logic [1:0]  eSize, eGrant;
        logic [31:0] eAddr, eDout;
        logic [31:0] eDi[2];
        logic        eWt[2];
        int          o, other;
        @(negedge clk);
        eBusEn = 1'b0; eBusWr = 1'b0; eTo = 1'b0; selEn = 1'b0; hit = 1'b0;
        eSize = 2'b00; eAddr = 32'h0; eDout = 32'h0;
        eDi[0] = 32'h0; eDi[1] = 32'h0; eWt[0] = 1'b1; eWt[1] = 1'b1;
        eGrant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        o = (owner < 0) ? 0 : owner;
        other = 1 - o;
        if (owner >= 0) begin
            selEn  = mEn[o];
            eBusEn = selEn;
            eBusWr = mWr[o];
            eSize  = mSize[o];
            eAddr  = mAddr[o];
            eDout  = mData[o];
            hit    = selEn && bus_wt && (waitRun == T - 1);
            eTo    = hit;
            eWt[o] = hit ? 1'b0 : bus_wt;
            eDi[o] = hit ? 32'h0 : bus_data_in;
        end
        checkOutput("bus_en", 32'(bus_en), 32'(eBusEn));
        checkOutput("bus_wr", 32'(bus_wr), 32'(eBusWr));
        checkOutput("bus_size", 32'(bus_size), 32'(eSize));
        checkOutput("bus_addr", bus_addr, eAddr);
        checkOutput("bus_data_out", bus_data_out, eDout);
        checkOutput("m0_data_in", m0_data_in, eDi[0]);
        checkOutput("m1_data_in", m1_data_in, eDi[1]);
        checkOutput("m0_wt", 32'(m0_wt), 32'(eWt[0]));
        checkOutput("m1_wt", 32'(m1_wt), 32'(eWt[1]));
        checkOutput("bus_timeout", 32'(bus_timeout), 32'(eTo));
        checkOutput("grant", 32'(grant), 32'(eGrant));
        doneFlag[0] = m0_en && !m0_wt;
        doneFlag[1] = m1_en && !m1_wt;
        if (owner < 0) begin
            if (mEn[0] && mEn[1]) owner = 1 - lastServed;
            else if (mEn[0])      owner = 0;
            else if (mEn[1])      owner = 1;
            waitRun = 0;
        end else if (!selEn) begin
            owner   = -1;
            waitRun = 0;
        end else if (!bus_wt || hit) begin
            lastServed = o;
            owner      = mEn[other] ? other : -1;
            waitRun    = 0;
        end else begin
            waitRun++;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearMasters();
        mAddr[0] = 32'hFFFF_0000; mData[1] = 32'hCAFE_F00D;
        drivePorts();
        bus_wt = 1'b0; bus_data_in = 32'h1234_5678;
        nextCycle();
        checkOutput("rst grant", 32'(grant), 32'h0);
        checkOutput("rst bus_en", 32'(bus_en), 32'h0);
        checkOutput("rst m0_wt", 32'(m0_wt), 32'h1);
        checkOutput("rst m1_wt", 32'(m1_wt), 32'h1);
        checkOutput("rst bus_addr", bus_addr, 32'h0);
        checkOutput("rst bus_data_out", bus_data_out, 32'h0);
        checkOutput("rst m0_data_in", m0_data_in, 32'h0);
        checkOutput("rst m1_data_in", m1_data_in, 32'h0);
        checkOutput("rst bus_timeout", 32'(bus_timeout), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        clearMasters();
        modelReset();
        nextCycle();
    endtask

    task automatic idleCycles(input int n);
        clearMasters();
        bus_wt = 1'b0;
        for (int i = 0; i < n; i++) begin
            sampleCycle();
            nextCycle();
        end
    endtask

    // Random masters hold a request until it is accepted, occasionally abandoning it.
    task automatic applyStimulus();
        for (int i = 0; i < 2; i++) begin
            if (doneFlag[i]) active[i] = 1'b0;
            if (!active[i]) begin
                mWr[i] = 1'($urandom); mSize[i] = 2'($urandom);
                mAddr[i] = $urandom; mData[i] = $urandom;
                if ($urandom_range(0, 2) == 0) active[i] = 1'b1;
            end else if ($urandom_range(0, 31) == 0) begin
                active[i] = 1'b0;
            end
            mEn[i] = active[i];
            doneFlag[i] = 1'b0;
        end
        drivePorts();
        bus_data_in = $urandom;
        if (stuckLeft > 0) begin
            bus_wt = 1'b1;
            stuckLeft--;
        end else begin
            if ($urandom_range(0, 40) == 0) stuckLeft = $urandom_range(3, 12);
            bus_wt = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        modelReset();
        clearMasters();
        doReset();

        // m0 read from a zero-wait slave.
        mEn[0] = 1'b1; mWr[0] = 1'b0; mSize[0] = 2'b10; mAddr[0] = 32'h0000_1000;
        drivePorts();
        bus_wt = 1'b0; bus_data_in = 32'hDEAD_BEEF;
        sampleCycle();
        checkOutput("t1 bus_en request cycle", 32'(bus_en), 32'h0);
        nextCycle();
        sampleCycle();
        checkOutput("t1 bus_en", 32'(bus_en), 32'h1);
        checkOutput("t1 m0_data_in", m0_data_in, 32'hDEAD_BEEF);
        checkOutput("t1 m0_wt", 32'(m0_wt), 32'h0);
        checkOutput("t1 grant", 32'(grant), 32'h1);
        nextCycle();
        mEn[0] = 1'b0; drivePorts();
        sampleCycle();
        checkOutput("t1 grant after", 32'(grant), 32'h0);
        nextCycle();

        // Both masters hammering the bus alternate with no idle cycles.
        doReset();
        for (int i = 0; i < 2; i++) begin
            mEn[i] = 1'b1; mWr[i] = 1'b0; mSize[i] = 2'b10; mAddr[i] = 32'h100 * (i + 1);
        end
        drivePorts();
        bus_wt = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus_data_in = 32'hA000_0000 + k;
            sampleCycle();
            if (k > 0) begin
                checkOutput("t2 grant", 32'(grant), (k % 2 == 1) ? 32'h1 : 32'h2);
                if (k % 2 == 1) checkOutput("t2 m1_wt", 32'(m1_wt), 32'h1);
            end
            nextCycle();
        end
        idleCycles(2);

        // m1 write with three wait states.
        mEn[1] = 1'b1; mWr[1] = 1'b1; mSize[1] = 2'b10;
        mAddr[1] = 32'h3040_0000; mData[1] = 32'h1234_5678;
        drivePorts();
        bus_wt = 1'b1;
        sampleCycle();
        for (int w = 1; w <= 4; w++) begin
            nextCycle();
            bus_wt = (w < 4);
            sampleCycle();
            checkOutput("t3 bus_data_out", bus_data_out, 32'h1234_5678);
            checkOutput("t3 m1_wt", 32'(m1_wt), (w < 4) ? 32'h1 : 32'h0);
            checkOutput("t3 bus_timeout", 32'(bus_timeout), 32'h0);
        end
        nextCycle();
        idleCycles(1);

        // Watchdog with a slave stuck in wait; then again with m1 queued behind.
        for (int pass = 0; pass < 2; pass++) begin
            clearMasters();
            mEn[0] = 1'b1; mAddr[0] = 32'h0000_2000;
            drivePorts();
            bus_wt = 1'b1; bus_data_in = 32'hA5A5_A5A5;
            sampleCycle();
            for (int g = 1; g <= T; g++) begin
                nextCycle();
                if (pass == 1) begin
                    mEn[1] = 1'b1; mAddr[1] = 32'h0000_3000; drivePorts();
                end
                sampleCycle();
                checkOutput("t4 bus_timeout", 32'(bus_timeout), (g == T) ? 32'h1 : 32'h0);
                checkOutput("t4 m0_wt", 32'(m0_wt), (g == T) ? 32'h0 : 32'h1);
                if (g == T) checkOutput("t4 m0_data_in", m0_data_in, 32'h0);
            end
            nextCycle();
            mEn[0] = 1'b0; drivePorts();
            bus_wt = 1'b0;
            sampleCycle();
            checkOutput("t4 grant after hit", 32'(grant), (pass == 1) ? 32'h2 : 32'h0);
            if (pass == 1) checkOutput("t5 m1_wt", 32'(m1_wt), 32'h0);
            nextCycle();
            idleCycles(1);
        end

        // Reset during the second wait cycle of an m1 transfer.
        mEn[1] = 1'b1; mAddr[1] = 32'h0000_4000;
        drivePorts();
        bus_wt = 1'b1;
        sampleCycle();
        nextCycle();
        sampleCycle();
        nextCycle();
        #2 reset = 1'b1;
        #1;
        checkOutput("t6 bus_en in reset", 32'(bus_en), 32'h0);
        checkOutput("t6 m1_wt in reset", 32'(m1_wt), 32'h1);
        checkOutput("t6 grant in reset", 32'(grant), 32'h0);
        clearMasters();
        bus_wt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        nextCycle();
        mEn[0] = 1'b1; mEn[1] = 1'b1; drivePorts();
        sampleCycle();
        nextCycle();
        sampleCycle();
        checkOutput("t6 tie after reset", 32'(grant), 32'h1);
        nextCycle();
        idleCycles(2);

        // Random traffic against the model.
        clearMasters();
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            sampleCycle();
            nextCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
